// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one FIFO write port
// between NUM_REQ requesters. Each accepted beat is tagged with its
// requester ID. Once a multi-beat burst has started, the grant stays with
// that requester until its last beat, so bursts never interleave in the FIFO.
//
// Handshake: requester k's beat moves when req_valid_i[k] && req_ready_o[k].
// On the FIFO side a beat is written when fifo_wr_valid_o is high. That
// strobe already includes !fifo_full_i, so the FIFO needs no ready of its own.
// Ready depends combinationally on valid and full. Valid never depends on ready.
//
// busy_o is the FSM state (BURST) exposed for observation.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ-1:0]             req_last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           fifo_wr_valid_o,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_data_o,
  input  logic                           fifo_full_i,
  output logic                           busy_o,
  output logic [ID_WIDTH-1:0]            grant_id_o
);

  localparam logic [ID_WIDTH:0] NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] grant_q;
  logic [ID_WIDTH-1:0] rr_ptr;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [ID_WIDTH-1:0]   cand;
  logic [ID_WIDTH-1:0]   winner;
  logic                  winner_found;
  logic                  xfer;
  logic                  winner_last;

  // Modular add within 0..NUM_REQ-1. The wrap is explicit so that a
  // non-power-of-two NUM_REQ never produces an out-of-range ID.
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                   input logic [ID_WIDTH:0]   ofs);
    logic [ID_WIDTH:0] s;
    s = {1'b0, base} + ofs;
    if (s >= NUM_REQ_W) s = s - NUM_REQ_W;
    return s[ID_WIDTH-1:0];
  endfunction

  // Split the flat data bus into one slice per requester.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      data_arr[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Winner selection: the burst owner in BURST; otherwise the first valid
  // requester starting at rr_ptr. While reset is asserted nothing is
  // selected, so all outputs stay at zero even if requesters are valid.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    cand         = '0;
    if (rst_n) begin
      if (state == BURST) begin
        winner       = grant_q;
        winner_found = 1'b1;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          cand = wrap_add(rr_ptr, (ID_WIDTH+1)'(i));
          if (!winner_found && req_valid_i[cand]) begin
            winner       = cand;
            winner_found = 1'b1;
          end
        end
      end
    end
  end

  // Transfer qualification and the output datapath.
  always_comb begin
    xfer            = winner_found && req_valid_i[winner] && !fifo_full_i;
    winner_last     = req_last_i[winner];
    fifo_wr_valid_o = xfer;
    fifo_data_o     = winner_found ? {winner, data_arr[winner]} : '0;
    grant_id_o      = winner;
    busy_o          = (state == BURST);
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready_o[k] = xfer && (winner == ID_WIDTH'(k));
    end
  end

  // FSM: a burst is locked in on a non-last beat accepted in IDLE. The
  // pointer advances past a requester only when its burst completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= '0;
      rr_ptr  <= '0;
    end else if (xfer) begin
      if (state == IDLE) begin
        if (winner_last) begin
          rr_ptr <= wrap_add(winner, (ID_WIDTH+1)'(1));
        end else begin
          state   <= BURST;
          grant_q <= winner;
        end
      end else if (winner_last) begin
        state  <= IDLE;
        rr_ptr <= wrap_add(grant_q, (ID_WIDTH+1)'(1));
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter. A 4-requester instance is checked on every
// cycle against a round-robin reference model. A 3-requester instance
// exercises the non-power-of-two pointer wrap. Directed ID sequences pin
// the model to hand-computed results.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-way DUT
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_wr_valid;
  logic [IW+DW-1:0] fifo_data;
  logic            fifo_full;
  logic            busy;
  logic [IW-1:0]   grant_id;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_last_i(req_last), .req_data_i(req_data),
    .req_ready_o(req_ready), .fifo_wr_valid_o(fifo_wr_valid),
    .fifo_data_o(fifo_data), .fifo_full_i(fifo_full),
    .busy_o(busy), .grant_id_o(grant_id)
  );

  // 3-way DUT
  logic [2:0]  v3;
  logic [2:0]  l3;
  logic [23:0] d3;
  logic [2:0]  ready3;
  logic        wr3;
  logic [9:0]  data3;
  logic        busy3;
  logic [1:0]  gid3;

  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(v3), .req_last_i(l3), .req_data_i(d3),
    .req_ready_o(ready3), .fifo_wr_valid_o(wr3),
    .fifo_data_o(data3), .fifo_full_i(1'b0),
    .busy_o(busy3), .grant_id_o(gid3)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [IW+DW-1:0] exp_q[$];
  int wr_log[$];
  int log3[$];
  int exp_ids[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_ids(input string name, input bit three);
    int got[$];
    if (three) got = log3; else got = wr_log;
    chk({name, "_count"}, 64'(got.size()), 64'(exp_ids.size()));
    for (int i = 0; i < exp_ids.size() && i < got.size(); i++)
      chk({name, "_id"}, 64'(got[i]), 64'(exp_ids[i]));
    wr_log.delete();
    log3.delete();
  endtask

  // reference model state: burst owner or -1, round-robin start position
  int  m_owner;
  int  m_ptr;
  int  m_win;
  bit  m_found;
  bit  m_xfer;
  logic [N-1:0] m_ready;

  // per-cycle comparison against the model, evaluated mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_wr_valid", 64'(fifo_wr_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant_id", 64'(grant_id), 64'd0);
      chk("rst_data", 64'(fifo_data), 64'd0);
    end else begin
      m_found = 1'b0;
      m_win   = 0;
      if (m_owner >= 0) begin
        m_win   = m_owner;
        m_found = 1'b1;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (!m_found && req_valid[(m_ptr + i) % N]) begin
            m_win   = (m_ptr + i) % N;
            m_found = 1'b1;
          end
        end
      end
      m_xfer  = m_found && req_valid[m_win] && !fifo_full;
      m_ready = m_xfer ? (N'(1) << m_win) : '0;
      chk("ready", 64'(req_ready), 64'(m_ready));
      chk("wr_valid", 64'(fifo_wr_valid), 64'(m_xfer));
      chk("busy", 64'(busy), 64'(m_owner >= 0));
      if (m_owner >= 0 || m_xfer) chk("grant_id", 64'(grant_id), 64'(m_win));
      if (m_xfer) exp_q.push_back({IW'(m_win), req_data[m_win*DW +: DW]});
      if (fifo_wr_valid) begin
        wr_log.push_back(int'(fifo_data[DW +: IW]));
        if (exp_q.size() == 0) chk("unexpected_write", 64'(fifo_data), 64'd0);
        else chk("wr_data", 64'(fifo_data), 64'(exp_q.pop_front()));
      end
      // state the model expects after the coming rising edge
      if (m_xfer) begin
        if (req_last[m_win]) begin
          m_owner = -1;
          m_ptr   = (m_win + 1) % N;
        end else begin
          m_owner = m_win;
        end
      end
      if (wr3) log3.push_back(int'(data3[9:8]));
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
    @(posedge clk);
    #1;
    req_valid = v;
    req_last  = l;
    fifo_full = f;
    req_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic step3(input logic [2:0] v, input logic [2:0] l);
    @(posedge clk);
    #1;
    v3 = v;
    l3 = l;
    d3 = 24'($urandom());
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
    req_valid = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    v3 = '0;
    l3 = '0;
    #6;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    v3 = '0;
    l3 = '0;
    d3 = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_idle_outputs", 64'({req_ready, fifo_wr_valid, busy, grant_id}), 64'd0);
    chk("reset_idle_data", 64'(fifo_data), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    chk("post_reset_outputs", 64'({req_ready, fifo_wr_valid, busy, grant_id}), 64'd0);

    // 3 requesters: requester 2 bursts, the pointer wraps to 0
    step3(3'b100, 3'b000);
    step3(3'b100, 3'b100);
    step3(3'b111, 3'b111);
    #3;
    chk("wrap3_ready", 64'(ready3), 64'b001);
    step3(3'b111, 3'b111);
    step3(3'b111, 3'b111);
    step3(3'b111, 3'b111);
    settle();
    exp_ids = '{2, 2, 0, 1, 2, 0};
    check_ids("wrap3", 1'b1);

    // all four valid, single-beat bursts back to back
    repeat (5) step(4'b1111, 4'b1111, 1'b0);
    settle();
    exp_ids = '{0, 1, 2, 3, 0};
    check_ids("rr_all", 1'b0);

    // requester 2 bursts 4 beats while 0 and 3 wait (pointer is at 1)
    step(4'b1101, 4'b1001, 1'b0);
    #3;
    chk("burst_beat1_busy", 64'(busy), 64'd0);
    step(4'b1101, 4'b1001, 1'b0);
    #3;
    chk("burst_beat2_busy", 64'(busy), 64'd1);
    step(4'b1101, 4'b1001, 1'b0);
    step(4'b1101, 4'b1101, 1'b0);
    #3;
    chk("burst_beat4_busy", 64'(busy), 64'd1);
    step(4'b1001, 4'b1001, 1'b0);
    #3;
    chk("burst_after_busy", 64'(busy), 64'd0);
    step(4'b0001, 4'b0001, 1'b0);
    settle();
    exp_ids = '{2, 2, 2, 2, 3, 0};
    check_ids("burst4", 1'b0);

    // FIFO full for 3 cycles inside a requester-1 burst
    step(4'b0011, 4'b0001, 1'b0);
    step(4'b0011, 4'b0001, 1'b0);
    repeat (3) begin
      step(4'b0011, 4'b0001, 1'b1);
      #3;
      chk("full_ready", 64'(req_ready), 64'd0);
      chk("full_wr_valid", 64'(fifo_wr_valid), 64'd0);
    end
    step(4'b0011, 4'b0001, 1'b0);
    step(4'b0011, 4'b0011, 1'b0);
    step(4'b0001, 4'b0001, 1'b0);
    settle();
    exp_ids = '{1, 1, 1, 1, 0};
    check_ids("full_stall", 1'b0);

    // requester 1 drops valid for 2 cycles mid-burst, requester 0 waits
    step(4'b0011, 4'b0001, 1'b0);
    repeat (2) begin
      step(4'b0001, 4'b0001, 1'b0);
      #3;
      chk("gap_wr_valid", 64'(fifo_wr_valid), 64'd0);
      chk("gap_ready", 64'(req_ready), 64'd0);
    end
    step(4'b0011, 4'b0001, 1'b0);
    step(4'b0011, 4'b0011, 1'b0);
    step(4'b0001, 4'b0001, 1'b0);
    settle();
    exp_ids = '{1, 1, 1, 0};
    check_ids("valid_gap", 1'b0);

    // asynchronous reset in the middle of a requester-3 burst
    step(4'b1000, 4'b0000, 1'b0);
    step(4'b1000, 4'b0000, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready_wr", 64'({req_ready, fifo_wr_valid}), 64'd0);
    chk("async_rst_busy_gid", 64'({busy, grant_id}), 64'd0);
    chk("async_rst_data", 64'(fifo_data), 64'd0);
    #3;
    exp_ids = '{3, 3};
    check_ids("pre_reset", 1'b0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 4'b1010;
    req_last  = 4'b1010;
    step(4'b1010, 4'b1010, 1'b0);
    settle();
    exp_ids = '{1, 3};
    check_ids("post_reset", 1'b0);

    chk("leftover_expected_writes", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
